wb_ram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single-port on-chip RAM slave between the instruction-fetch master (M0) and the load/store master (M1). It sits between the core's two bus masters and the RAM's Wishbone slave port. It uses registered round-robin grant with cycle locking, and a watchdog that revokes a grant stuck without acknowledge.

---
 rtl/wb_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port on-chip RAM.
// M0 is instruction fetch, M1 is load/store. The grant is registered and
// round-robin. Once a master is granted it keeps the bus for as long as it
// holds cyc. A watchdog takes the bus away from a master that waits too long
// for an ack, and locks that master out until it drops cyc.
//
// Handshake: a master asks for a transfer by holding cyc=1 and stb=1. The
// transfer finishes in the cycle the slave returns ack=1. For the granted
// master, the arbiter passes cyc/stb/ack through combinationally, so it adds
// no wait states. The master that is not granted always sees ack=0 and data=0.

package wb_ram_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_m2s_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ack;
  } wb_s2m_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;
endpackage

`ifndef WB_M2S
`define WB_M2S wb_ram_arbiter_pkg::wb_m2s_t
`endif
`ifndef WB_S2M
`define WB_S2M wb_ram_arbiter_pkg::wb_s2m_t
`endif

module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TCNT_W         = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  `WB_M2S      i_m2s_wb0,
  output `WB_S2M      o_s2m_wb0,
  input  `WB_M2S      i_m2s_wb1,
  output `WB_S2M      o_s2m_wb1,
  output `WB_M2S      o_m2s_wb,
  input  `WB_S2M      i_s2m_wb,
  output logic [1:0]  o_gnt,
  output logic        o_timeout,
  output arb_state_t  o_dbg_state
);

  localparam logic              WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] T_LIM = TCNT_W'(TIMEOUT_CYCLES);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;      // 0: M0 served last, 1: M1 served last
  logic [1:0]        lock_q, lock_d;
  logic [TCNT_W-1:0] wdog_q, wdog_d;

  logic [1:0] req_cyc;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       stalled;
  logic       timeout;

  assign req_cyc = {i_m2s_wb1.cyc, i_m2s_wb0.cyc};
  assign elig    = req_cyc & ~lock_q;
  assign gnt     = {state_q == ST_GNT1, state_q == ST_GNT0};

  // The forwarded request is all zero in IDLE, so no extra state gating is needed here.
  assign stalled = o_m2s_wb.stb & o_m2s_wb.cyc & ~i_s2m_wb.ack;
  assign timeout = WD_EN && (state_q != ST_IDLE) && (wdog_q == T_LIM);

  assign o_gnt       = gnt;
  assign o_timeout   = timeout;
  assign o_dbg_state = state_q;

  // Arbiter state, round-robin pointer, lockouts and watchdog counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      lock_q  <= 2'b00;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next grant. A release or a timeout hands the bus straight to the other master if it is eligible.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (elig == 2'b11) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (elig[0])  state_d = ST_GNT0;
        else if (elig[1])  state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (timeout || !i_m2s_wb0.cyc) begin
          last_d  = 1'b0;
          state_d = elig[1] ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (timeout || !i_m2s_wb1.cyc) begin
          last_d  = 1'b1;
          state_d = elig[0] ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A lockout is set on the revoked master and cleared once that master is seen with cyc low.
  always_comb begin
    lock_d = (lock_q & req_cyc) | (timeout ? gnt : 2'b00);
  end

  // The watchdog counts only stalled cycles of an unchanged grant. An ack, stb=0, or a grant change clears it.
  always_comb begin
    wdog_d = '0;
    if (WD_EN && (state_q != ST_IDLE) && (state_d == state_q) && stalled) begin
      wdog_d = (wdog_q == T_LIM) ? wdog_q : wdog_q + 1'b1;
    end
  end

  // Route the request of the granted master to the RAM, and the RAM response back to that master.
  always_comb begin
    o_m2s_wb  = '0;
    o_s2m_wb0 = '0;
    o_s2m_wb1 = '0;
    case (state_q)
      ST_GNT0: begin
        o_m2s_wb  = i_m2s_wb0;
        o_s2m_wb0 = i_s2m_wb;
      end
      ST_GNT1: begin
        o_m2s_wb  = i_m2s_wb1;
        o_s2m_wb1 = i_s2m_wb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios with literal expectations, then
// random traffic checked against a transaction-level model of the arbiter.
module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  localparam int          TMO   = 4;
  localparam logic [31:0] D_KEY = 32'h5A5A_1234;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic rstn  = 1'b0;
  always #5 i_clk = ~i_clk;

  wb_m2s_t    m0 = '0, m1 = '0;
  wb_s2m_t    s2m0, s2m1, s2m_slave;
  wb_m2s_t    m2s;
  logic [1:0] gnt;
  logic       tmo;
  arb_state_t dbg_state;
  logic       stall = 1'b0;

  wb_ram_arbiter #(.TIMEOUT_CYCLES(TMO), .TCNT_W(3)) dut (
    .i_clk       (i_clk),
    .i_rstn      (rstn),
    .i_m2s_wb0   (m0),
    .o_s2m_wb0   (s2m0),
    .i_m2s_wb1   (m1),
    .o_s2m_wb1   (s2m1),
    .o_m2s_wb    (m2s),
    .i_s2m_wb    (s2m_slave),
    .o_gnt       (gnt),
    .o_timeout   (tmo),
    .o_dbg_state (dbg_state)
  );

  // RAM slave stand-in: combinational ack unless stalled; read data derived from address.
  always_comb begin
    s2m_slave.data = m2s.addr ^ D_KEY;
    s2m_slave.ack  = !stall && m2s.stb && m2s.cyc;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 = nobody, 0 = M0, 1 = M1. stall_run: consecutive stalled cycles of the current owner.
  int owner = -1;
  int last_served = 1;
  bit locked[2] = '{0, 0};
  int stall_run = 0;

  wb_m2s_t mdl_rq[2];
  int      mdl_next;
  bit      mdl_tmo, mdl_ack;

  always @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      owner = -1; last_served = 1; locked[0] = 0; locked[1] = 0; stall_run = 0;
    end else begin
      mdl_rq[0] = m0;
      mdl_rq[1] = m1;
      mdl_tmo = (owner >= 0) && (stall_run == TMO);
      mdl_ack = (owner >= 0) && !stall && mdl_rq[owner].stb && mdl_rq[owner].cyc;
      if (owner < 0) begin
        if (mdl_rq[0].cyc && !locked[0] && mdl_rq[1].cyc && !locked[1]) mdl_next = 1 - last_served;
        else if (mdl_rq[0].cyc && !locked[0]) mdl_next = 0;
        else if (mdl_rq[1].cyc && !locked[1]) mdl_next = 1;
        else mdl_next = -1;
      end else if (mdl_tmo || !mdl_rq[owner].cyc) begin
        last_served = owner;
        mdl_next = (mdl_rq[1-owner].cyc && !locked[1-owner]) ? 1 - owner : -1;
      end else begin
        mdl_next = owner;
      end
      for (int i = 0; i < 2; i++) begin
        if (mdl_tmo && owner == i) locked[i] = 1;
        else if (!mdl_rq[i].cyc)   locked[i] = 0;
      end
      if (mdl_next != owner || owner < 0) stall_run = 0;
      else if (mdl_rq[owner].stb && !mdl_ack) stall_run = stall_run + 1;
      else stall_run = 0;
      owner = mdl_next;
    end
  end

  // Compare DUT against the model once per cycle, mid-cycle.
  always @(negedge i_clk) begin : compare
    wb_m2s_t    e_m2s;
    wb_s2m_t    e_rsp;
    logic [1:0] e_gnt;
    e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_m2s = (owner == 0) ? m0 : (owner == 1) ? m1 : '0;
    e_rsp.data = e_m2s.addr ^ D_KEY;
    e_rsp.ack  = !stall && e_m2s.stb && e_m2s.cyc;
    chk("gnt", 80'(gnt), 80'(e_gnt));
    chk("timeout", 80'(tmo), 80'((owner >= 0) && (stall_run == TMO)));
    chk("m2s", 80'(m2s), 80'(e_m2s));
    chk("s2m0", 80'(s2m0), (owner == 0) ? 80'(e_rsp) : 80'(0));
    chk("s2m1", 80'(s2m1), (owner == 1) ? 80'(e_rsp) : 80'(0));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req(input int m, input logic c, input logic s);
    wb_m2s_t r;
    r.addr = $urandom; r.data = $urandom; r.sel = 4'($urandom_range(0, 15));
    r.we = 1'($urandom_range(0, 1)); r.stb = s; r.cyc = c;
    if (m == 0) m0 = r; else m1 = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a0;
    // Reset state, outputs checked while reset is held.
    #3;
    chk("rst_gnt", 80'(gnt), 80'(2'b00));
    chk("rst_timeout", 80'(tmo), 80'(1'b0));
    chk("rst_m2s", 80'(m2s), 80'(0));
    chk("rst_s2m0", 80'(s2m0), 80'(0));
    chk("rst_s2m1", 80'(s2m1), 80'(0));
    tick(); tick();
    rstn = 1'b1;

    // Single master.
    tick();
    req(0, 1, 1); a0 = m0.addr;
    tick();
    chk("single_gnt", 80'(gnt), 80'(2'b01));
    chk("single_ack0", 80'(s2m0.ack), 80'(1'b1));
    chk("single_ack1", 80'(s2m1.ack), 80'(1'b0));
    chk("single_addr", 80'(m2s.addr), 80'(a0));
    chk("single_data0", 80'(s2m0.data), 80'(a0 ^ D_KEY));
    req(0, 0, 0);
    tick();
    chk("single_idle", 80'(gnt), 80'(2'b00));

    // Tie after reset: M0 first, then handover without an idle cycle.
    rstn = 1'b0; #2; rstn = 1'b1;
    tick();
    req(0, 1, 1); req(1, 1, 1);
    tick(); chk("tie_first", 80'(gnt), 80'(2'b01));
    chk("tie_model", 80'(owner), 80'(0));
    tick(); chk("tie_hold1", 80'(gnt), 80'(2'b01));
    tick(); chk("tie_hold2", 80'(gnt), 80'(2'b01));
    req(0, 0, 0);
    tick(); chk("tie_handover", 80'(gnt), 80'(2'b10));
    req(1, 0, 0);
    tick(); chk("tie_idle", 80'(gnt), 80'(2'b00));

    // Round-robin: each master ends its cycle in the cycle it is acked.
    req(0, 1, 1); req(1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", 80'(gnt), 80'((k % 2 == 0) ? 2'b01 : 2'b10));
      @(negedge i_clk); #1;
      if (s2m0.ack) req(0, 0, 0); else if (!m0.cyc) req(0, 1, 1);
      if (s2m1.ack) req(1, 0, 0); else if (!m1.cyc) req(1, 1, 1);
    end
    req(0, 0, 0); req(1, 0, 0);
    tick(); tick();
    chk("rr_idle", 80'(gnt), 80'(2'b00));

    // Lock: M1 keeps cyc high while stb toggles, and M0 waits.
    req(1, 1, 1);
    tick(); chk("lock_gnt1", 80'(gnt), 80'(2'b10));
    req(0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("lock_hold", 80'(gnt), 80'(2'b10));
      chk("lock_ack0", 80'(s2m0.ack), 80'(1'b0));
      m1.stb = ~m1.stb;
    end
    req(1, 0, 0);
    tick(); chk("lock_release", 80'(gnt), 80'(2'b01));
    req(0, 0, 0);
    tick(); chk("lock_idle", 80'(gnt), 80'(2'b00));

    // Watchdog with a stalled slave.
    stall = 1'b1;
    req(0, 1, 1);
    tick(); chk("wd_gnt", 80'(gnt), 80'(2'b01));
    chk("wd_no_tmo0", 80'(tmo), 80'(1'b0));
    for (int k = 1; k < TMO; k++) begin
      tick(); chk("wd_no_tmo", 80'(tmo), 80'(1'b0));
    end
    tick(); chk("wd_tmo", 80'(tmo), 80'(1'b1));
    chk("wd_tmo_gnt", 80'(gnt), 80'(2'b01));
    tick(); chk("wd_revoked", 80'(gnt), 80'(2'b00));
    chk("wd_tmo_clear", 80'(tmo), 80'(1'b0));
    chk("wd_model_lock", 80'(locked[0]), 80'(1'b1));
    for (int k = 0; k < 3; k++) begin
      tick(); chk("wd_locked_out", 80'(gnt), 80'(2'b00));
    end
    req(0, 0, 0);
    tick();
    req(0, 1, 1);
    tick(); chk("wd_regrant", 80'(gnt), 80'(2'b01));
    stall = 1'b0;
    req(0, 0, 0);
    tick(); tick();

    // Async reset in the middle of an M1 transfer.
    req(1, 1, 1);
    tick(); chk("ar_gnt1", 80'(gnt), 80'(2'b10));
    tick();
    #2; rstn = 1'b0;
    #1;
    chk("ar_gnt", 80'(gnt), 80'(2'b00));
    chk("ar_cyc", 80'(m2s.cyc), 80'(1'b0));
    chk("ar_s2m1", 80'(s2m1), 80'(0));
    req(0, 1, 1);
    @(posedge i_clk); #3; rstn = 1'b1;
    tick(); chk("ar_m0_first", 80'(gnt), 80'(2'b01));
    req(0, 0, 0); req(1, 0, 0);
    tick(); tick();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 11) == 0) stall = ~stall;
      for (int m = 0; m < 2; m++) begin
        logic c;
        c = (m == 0) ? m0.cyc : m1.cyc;
        if (c) c = ($urandom_range(0, 5) != 0);
        else   c = ($urandom_range(0, 1) == 1);
        req(m, c, c && ($urandom_range(0, 3) != 0));
      end
    end
    stall = 1'b0;
    req(0, 0, 0); req(1, 0, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
